// File: rtl/sipo_16.sv
// sipo_16: MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
module sipo_16 #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     shift_en,
  input  logic                     serial_in,
  input  logic                     data_ready,
  input  logic                     clr_overrun,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word;
  logic strobe, complete, restart, drop;
  always_comb begin
    strobe   = state == SHIFT && shift_en;
    complete = strobe && bit_cnt == CW'(WIDTH - 1);
    restart  = state == SHIFT && start && !complete;
    word     = {shift[WIDTH-2:0], serial_in};
    drop     = complete && data_valid && !data_ready;
    state_nx = state == IDLE ? (start ? SHIFT : IDLE)
             : complete      ? (start ? SHIFT : IDLE)
             :                 SHIFT;
  end
  assign busy = state == SHIFT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end
  // A restart wins over a coincident strobe; a completion wins over a coincident start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if ((state == IDLE && start) || restart) begin
      bit_cnt <= '0;
    end else if (strobe) begin
      shift   <= word;
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (complete && !drop) begin
      data_out   <= word;
      data_valid <= 1'b1;
    end else if (!complete && data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end
endmodule

// File: doc/sipo_16.md
Name: sipo_16

Overview:
- Serial-in/parallel-out receiver. It is the receiving end of the 16-bit MSB-first serial link driven by our PISO shifter.
- Samples serial_in on qualified bit strobes after a frame start and assembles WIDTH bits.
- Presents each completed word on a registered parallel output, using a valid/ready handshake and a sticky overrun flag.
- Sits between the serial link and downstream parallel logic.

Parameters:
- WIDTH, 16, number of bits per frame (minimum 2); sets data_out width and bit_cnt range.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame-start pulse; arms reception of a new frame.
- shift_en  input  1  bit strobe; serial_in is sampled only on edges where this is 1 while receiving.
- serial_in  input  1  serial data, MSB first.
- data_ready  input  1  downstream accepts data_out when high together with data_valid.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- data_out  output  WIDTH  last completed word.
- data_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  frame in progress (state SHIFT).
- bit_cnt  output  clog2(WIDTH)  bits received in the current frame.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async, rst=1): state IDLE, internal shift register 0, and all outputs 0 (data_out, data_valid, busy, bit_cnt, overrun). Reset during a frame discards the partial word and any pending word.
- FSM has two states, IDLE and SHIFT. busy = (state==SHIFT).
- IDLE:
  - start=1 -> SHIFT, bit_cnt<=0.
  - shift_en is ignored in IDLE, including on the same edge as start. The first bit is sampled on the first shift_en edge after entering SHIFT.
- SHIFT, shift_en=1:
  - shift <= {shift[WIDTH-2:0], serial_in}.
  - bit_cnt increments.
- SHIFT, shift_en=0: hold everything.
- Frame completion: SHIFT, shift_en=1, bit_cnt==WIDTH-1.
  - Completed word W = {shift[WIDTH-2:0], serial_in}.
  - bit_cnt<=0. Next state is IDLE, or SHIFT if start=1 on the same edge.
  - Latency: data_out/data_valid update on this edge, so they are visible in the cycle after the final sampling edge.
- Output handshake at the completion edge:
  - If data_valid=0, or data_valid=1 and data_ready=1: data_out<=W, data_valid<=1.
  - If data_valid=1 and data_ready=0: W is dropped, data_out and data_valid are unchanged, overrun<=1.
- Output handshake on other edges: data_valid=1 and data_ready=1 -> data_valid<=0, data_out holds its value.
- Restart: start=1 in SHIFT with no completion on that edge -> partial word discarded, bit_cnt<=0, stay in SHIFT. The shift_en on that edge is ignored.
- overrun:
  - Set only by a drop.
  - Cleared by clr_overrun=1.
  - A set and a clear on the same edge -> set wins.
- data_ready with data_valid=0 has no effect.
- Counter never exceeds WIDTH-1 and wraps to 0 only via completion or restart.

Test Plan:
- Reset mid-frame: start, 7 bits, then assert rst -> all outputs 0 immediately. After release, a fresh frame 16'h1234 is received correctly.
- Basic frame: start, then 16 consecutive shift_en with serial_in = 16'hA5C3 MSB first, data_ready=1 -> data_out=16'hA5C3 and data_valid=1 for exactly one cycle after the 16th strobe. busy goes 1->0; bit_cnt steps 0..15 then 0.
- Gapped strobes: same frame 16'h8001 with shift_en deasserted for 3 cycles between bits 5 and 6 -> data_out=16'h8001, no extra or missing bits. Strobe coincident with start is ignored.
- Back-to-back with backpressure:
  - 16'h00FF completes while data_ready=0 -> held in data_out.
  - Second word 16'hFF00 completes with data_ready still 0 -> data_out stays 16'h00FF, overrun=1.
  - clr_overrun -> overrun=0.
- Accept-and-complete same edge: data_valid=1 holding 16'h1111, data_ready=1 on the completion edge of 16'h2222 -> data_out=16'h2222, data_valid stays 1, overrun stays 0.
- Restart: start at bit 9 of a frame, then 16 bits of 16'hBEEF -> data_out=16'hBEEF, no overrun. Also, start on a completion edge -> word delivered and busy stays 1.
